pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
- Parametrised inter-stage pipeline register for the MIPS core: F/D, D/E, E/M and M/W boundaries.
- Carries instruction, PC, exception code and branch-delay bit.
- Replaces enable-style stalling with a valid/ready handshake and a one-entry skid buffer, so upstream ready is registered and stall paths are cut.
- Supports flush bubbles that preserve PC, and exception-request redirect to the handler PC.

Parameters:
- INSTR_W, 32, instruction payload width
- PC_W, 32, PC width
- EXC_W, 5, exception code width
- HANDLER_PC, 32'h0000_4180, PC loaded into the bubble on exception request
- SKID_EN, 1, 1 = skid buffer present; 0 = plain register, with in_ready = out_ready || !out_valid (combinational)

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- in_valid  in  1  upstream entry valid
- in_ready  out  1  stage can accept an entry
- in_instr  in  INSTR_W  upstream instruction
- in_pc  in  PC_W  upstream PC
- in_excode  in  EXC_W  upstream exception code (0 = none)
- in_bd  in  1  upstream branch-delay-slot flag
- out_valid  out  1  output register holds a real entry
- out_ready  in  1  downstream accepts this cycle
- out_instr  out  INSTR_W  registered instruction
- out_pc  out  PC_W  registered PC
- out_excode  out  EXC_W  registered exception code
- out_bd  out  1  registered delay-slot flag
- flush  in  1  kill in-flight entries, insert bubble keeping PC
- req  in  1  exception/interrupt redirect; insert bubble at HANDLER_PC

Behaviour:
- State: output register (OUT) and skid register (SKID) with skid_full flag.
- SKID_EN=1: in_ready = !skid_full, driven from a flop.
- Transfers:
  - Accept: in_valid && in_ready.
  - Drain: out_valid && out_ready.
- Normal cycle (no reset/req/flush):
  - If OUT is empty or draining: OUT loads SKID if skid_full (SKID clears), else loads the accepted input, else out_valid goes to 0.
  - If OUT is held and an input is accepted: the input goes to SKID and skid_full goes to 1.
  - SKID full and OUT draining with new input: OUT gets SKID, SKID gets the new input. Order is preserved and there is no loss.
- Priority is reset > req > flush > normal. All are synchronous and take effect at the next clk edge.
- reset: all outputs 0, skid_full 0, in_ready 1 in the following cycle.
- req: SKID discarded. OUT = {instr 0, pc HANDLER_PC, excode 0, bd 0}, out_valid 0. Upstream input that cycle is not accepted (in_ready is forced 0 combinationally).
- flush: SKID discarded. OUT = {instr 0, excode 0, out_valid 0}. pc and bd come from the oldest pending entry: SKID if skid_full, else in_pc/in_bd. Input that cycle is not accepted.
- Bubbles (out_valid 0) never assert an exception downstream, but their PC is still visible for EPC/macro-PC.
- Latency: 1 cycle input-to-output when unstalled. Full throughput is 1 entry/cycle.
- Backpressure:
  - OUT held while out_valid && !out_ready; contents stable.
  - SKID fills at most once; in_ready drops the cycle after SKID fills.
- No X propagation: payload registers are reset even when SKID_EN=0.

Optional Feature:
- Macro: PIPE_STAGE_PERF_EN.
- Defined: adds outputs perf_stall_cnt (32) and perf_bubble_cnt (32).
  - perf_stall_cnt increments each cycle out_valid && !out_ready.
  - perf_bubble_cnt increments on each flush/req bubble insertion.
  - Both saturate at all-ones and clear on reset.
- Undefined: ports and counters absent; the block is otherwise identical.

Decomposition:
- Shared package (cpu_pkg): EXC_W, the EXC_NONE=0 code, HANDLER_PC constant, and the stage_payload_t struct {instr, pc, excode, bd}.
- One natural sub-module: pipe_skid_buf. It holds the SKID register, skid_full and registered in_ready, instantiated under SKID_EN.

Test Plan:
- Reset then stream PC 0x3000, 0x3004, 0x3008 with out_ready=1 -> each appears on out_pc one cycle later, out_valid=1, in_ready constantly 1.
- Hold out_ready=0 while sending 0x3000, 0x3004 -> OUT=0x3000, SKID=0x3004, in_ready=0 next cycle. Release out_ready -> 0x3004 emitted next, no loss or duplication.
- SKID full (0x3004) plus flush -> out_valid=0, out_pc=0x3004, out_instr=0, out_excode=0, in_ready=1 next cycle.
- flush and req same cycle with in_pc=0x3010 -> out_pc=0x4180, out_valid=0, bd=0.
- in_excode=5'd4, in_bd=1 accepted -> out_excode=4, out_bd=1; reset mid-stall -> all outputs 0, skid empty.
- With PIPE_STAGE_PERF_EN: 3 stalled cycles plus 2 flushes -> perf_stall_cnt=3, perf_bubble_cnt=2.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared MIPS core definitions used by the pipeline-stage registers:
// exception code width, the "no exception" code, the handler PC and the stage payload.
package cpu_pkg;

  localparam int WORD_W = 32;
  localparam int EXC_W  = 5;

  localparam logic [EXC_W-1:0]  EXC_NONE   = '0;
  localparam logic [WORD_W-1:0] HANDLER_PC = 32'h0000_4180;

  typedef struct packed {
    logic [WORD_W-1:0] instr;
    logic [WORD_W-1:0] pc;
    logic [EXC_W-1:0]  excode;
    logic              bd;
  } stage_payload_t;

  // Bubble entry: carries a PC for EPC bookkeeping but never raises an exception.
  function automatic stage_payload_t make_bubble(input logic [WORD_W-1:0] pc,
                                                 input logic              bd);
    stage_payload_t p;
    p.instr  = '0;
    p.pc     = pc;
    p.excode = EXC_NONE;
    p.bd     = bd;
    return p;
  endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// One-entry skid buffer for pipe_stage_reg: holds the entry that arrives while
// the output register is stalled, and drives a registered upstream ready.
module pipe_skid_buf #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         discard,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] in_data,
  output logic [W-1:0] skid_data,
  output logic         skid_full,
  output logic         in_ready
);

  logic [W-1:0] data_q, data_d;
  logic         full_q, full_d;
  logic         ready_q, ready_d;

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
    data_d = data_q;
    full_d = full_q;
    if (discard) begin
      full_d = 1'b0;
    end else if (push) begin
      data_d = in_data;
      full_d = 1'b1;
    end else if (pop) begin
      full_d = 1'b0;
    end
    // Ready is a flop copy of "skid will be empty", so upstream sees no combinational stall path.
    ready_d = !full_d;
  end

  always_ff @(posedge clk) begin
    // NOTE: state flops use non-blocking assignments so every flop samples the pre-edge values.
    if (reset) begin
      data_q  <= '0;
      full_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      data_q  <= data_d;
      full_q  <= full_d;
      ready_q <= ready_d;
    end
  end

  assign skid_data = data_q;
  assign skid_full = full_q;
  assign in_ready  = ready_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready handshake, optional skid buffer,
// flush/exception bubbles. Define PIPE_STAGE_PERF_EN to add stall/bubble counters.
module pipe_stage_reg #(
  parameter int                INSTR_W    = 32,
  parameter int                PC_W       = 32,
  parameter int                EXC_W      = cpu_pkg::EXC_W,
  parameter logic [PC_W-1:0]   HANDLER_PC = cpu_pkg::HANDLER_PC,
  parameter bit                SKID_EN    = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [PC_W-1:0]    in_pc,
  input  logic [EXC_W-1:0]   in_excode,
  input  logic               in_bd,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [PC_W-1:0]    out_pc,
  output logic [EXC_W-1:0]   out_excode,
  output logic               out_bd,
  input  logic               flush,
  input  logic               req
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [31:0]        perf_stall_cnt,
  output logic [31:0]        perf_bubble_cnt
`endif
);

  import cpu_pkg::*;

  localparam int PW = INSTR_W + PC_W + EXC_W + 1;

  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [EXC_W-1:0]   excode_q, excode_d;
  logic               bd_q, bd_d;
  logic               valid_q, valid_d;

  logic [PW-1:0]      in_data;
  logic [PW-1:0]      skid_data;
  logic [INSTR_W-1:0] skid_instr;
  logic [PC_W-1:0]    skid_pc;
  logic [EXC_W-1:0]   skid_excode;
  logic               skid_bd;
  logic               skid_full;
  logic               skid_in_ready;
  logic               skid_push, skid_pop, skid_discard;

  logic               base_ready;
  logic               accept;
  logic               out_load_en;

  assign in_data = {in_instr, in_pc, in_excode, in_bd};
  assign {skid_instr, skid_pc, skid_excode, skid_bd} = skid_data;

  generate
    if (SKID_EN) begin : g_skid
      pipe_skid_buf #(
        .W (PW)
      ) u_skid (
        .clk       (clk),
        .reset     (reset),
        .discard   (skid_discard),
        .push      (skid_push),
        .pop       (skid_pop),
        .in_data   (in_data),
        .skid_data (skid_data),
        .skid_full (skid_full),
        .in_ready  (skid_in_ready)
      );
    end else begin : g_no_skid
      assign skid_data     = '0;
      assign skid_full     = 1'b0;
      assign skid_in_ready = 1'b1;
    end
  endgenerate

  // Redirects own this cycle: nothing from upstream may slip in behind them.
  always_comb begin
    if (SKID_EN) base_ready = skid_in_ready;
    else         base_ready = out_ready || !valid_q;
    in_ready = base_ready && !req && !flush;
  end

  assign accept      = in_valid && in_ready;
  assign out_load_en = !valid_q || out_ready;

  always_comb begin
    instr_d      = instr_q;
    pc_d         = pc_q;
    excode_d     = excode_q;
    bd_d         = bd_q;
    valid_d      = valid_q;
    skid_push    = 1'b0;
    skid_pop     = 1'b0;
    skid_discard = req || flush;

    if (req) begin
      instr_d  = '0;
      pc_d     = HANDLER_PC;
      excode_d = EXC_W'(EXC_NONE);
      bd_d     = 1'b0;
      valid_d  = 1'b0;
    end else if (flush) begin
      // The bubble keeps the PC of the oldest entry that has not yet reached OUT.
      instr_d  = '0;
      excode_d = EXC_W'(EXC_NONE);
      valid_d  = 1'b0;
      pc_d     = skid_full ? skid_pc : in_pc;
      bd_d     = skid_full ? skid_bd : in_bd;
    end else if (out_load_en) begin
      if (skid_full) begin
        instr_d   = skid_instr;
        pc_d      = skid_pc;
        excode_d  = skid_excode;
        bd_d      = skid_bd;
        valid_d   = 1'b1;
        skid_pop  = 1'b1;
        skid_push = accept;
      end else if (accept) begin
        instr_d  = in_instr;
        pc_d     = in_pc;
        excode_d = in_excode;
        bd_d     = in_bd;
        valid_d  = 1'b1;
      end else begin
        valid_d = 1'b0;
      end
    end else begin
      skid_push = accept;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: payload flops are reset along with valid so no X ever reaches downstream muxes or EPC.
      instr_q  <= '0;
      pc_q     <= '0;
      excode_q <= '0;
      bd_q     <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      instr_q  <= instr_d;
      pc_q     <= pc_d;
      excode_q <= excode_d;
      bd_q     <= bd_d;
      valid_q  <= valid_d;
    end
  end

  assign out_valid  = valid_q;
  assign out_instr  = instr_q;
  assign out_pc     = pc_q;
  assign out_excode = excode_q;
  assign out_bd     = bd_q;

`ifdef PIPE_STAGE_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] bubble_cnt_q, bubble_cnt_d;

  // Saturating counters: a wrapped count would read as "no stalls".
  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (valid_q && !out_ready && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 32'd1;
    if ((req || flush) && (bubble_cnt_q != '1))       bubble_cnt_d = bubble_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign perf_stall_cnt  = stall_cnt_q;
  assign perf_bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: directed plan followed by random traffic,
// all compared against a two-entry FIFO reference model.
module tb_pipe_stage_reg;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        reset, in_valid, in_bd, out_ready, flush, req;
  logic [31:0] in_instr, in_pc;
  logic [4:0]  in_excode;
  logic        in_ready, out_valid, out_bd;
  logic [31:0] out_instr, out_pc;
  logic [4:0]  out_excode;
`ifdef PIPE_STAGE_PERF_EN
  logic [31:0] perf_stall_cnt, perf_bubble_cnt;
`endif

  int errors = 0;
  int checks = 0;

  // Reference model: the stage behaves as a FIFO of depth 2 whose head is visible on OUT.
  stage_payload_t mq[$];
  stage_payload_t disp;
  int unsigned    m_stall, m_bubble;

  always #5 clk = ~clk;

  pipe_stage_reg dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_instr   (in_instr),
    .in_pc      (in_pc),
    .in_excode  (in_excode),
    .in_bd      (in_bd),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_instr  (out_instr),
    .out_pc     (out_pc),
    .out_excode (out_excode),
    .out_bd     (out_bd),
    .flush      (flush),
    .req        (req)
`ifdef PIPE_STAGE_PERF_EN
    ,
    .perf_stall_cnt  (perf_stall_cnt),
    .perf_bubble_cnt (perf_bubble_cnt)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_update(input bit rdy);
    stage_payload_t e;
    if (reset) begin
      mq.delete();
      disp     = '0;
      m_stall  = 0;
      m_bubble = 0;
      return;
    end
    if (mq.size() > 0 && !out_ready && m_stall != 32'hFFFF_FFFF) m_stall++;
    if (req) begin
      mq.delete();
      disp = make_bubble(HANDLER_PC, 1'b0);
      m_bubble++;
    end else if (flush) begin
      if (mq.size() == 2) disp = make_bubble(mq[1].pc, mq[1].bd);
      else                disp = make_bubble(in_pc, in_bd);
      mq.delete();
      m_bubble++;
    end else begin
      if (mq.size() > 0 && out_ready) void'(mq.pop_front());
      if (in_valid && rdy) begin
        e.instr  = in_instr;
        e.pc     = in_pc;
        e.excode = in_excode;
        e.bd     = in_bd;
        mq.push_back(e);
      end
    end
    if (mq.size() > 0) disp = mq[0];
  endtask

  task automatic step(input string tag);
    bit rdy_exp;
    #1;
    rdy_exp = (mq.size() < 2) && !req && !flush;
    if (!reset) check({tag, "/in_ready"}, 64'(in_ready), 64'(rdy_exp));
    @(posedge clk);
    model_update(rdy_exp);
    #1;
    check({tag, "/out_valid"},  64'(out_valid),  64'(mq.size() > 0));
    check({tag, "/out_instr"},  64'(out_instr),  64'(disp.instr));
    check({tag, "/out_pc"},     64'(out_pc),     64'(disp.pc));
    check({tag, "/out_excode"}, 64'(out_excode), 64'(disp.excode));
    check({tag, "/out_bd"},     64'(out_bd),     64'(disp.bd));
`ifdef PIPE_STAGE_PERF_EN
    check({tag, "/perf_stall"},  64'(perf_stall_cnt),  64'(m_stall));
    check({tag, "/perf_bubble"}, 64'(perf_bubble_cnt), 64'(m_bubble));
`endif
  endtask

  task automatic drive(input bit v, input logic [31:0] pc, input bit ordy);
    in_valid  = v;
    in_pc     = pc;
    in_instr  = pc ^ 32'hA5A5_0000;
    in_excode = '0;
    in_bd     = 1'b0;
    out_ready = ordy;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; req = 1'b0;
    drive(1'b0, 32'h0, 1'b1);
    step("reset");
    check("reset_pc_zero", 64'(out_pc), 64'h0);
    reset = 1'b0;

    // Unstalled stream: one-cycle latency, ready stays high.
    drive(1'b1, 32'h3000, 1'b1); step("s0");
    check("s0_pc", 64'(out_pc), 64'h3000);
    drive(1'b1, 32'h3004, 1'b1); step("s1");
    drive(1'b1, 32'h3008, 1'b1); step("s2");
    check("s2_pc", 64'(out_pc), 64'h3008);
    drive(1'b0, 32'h0, 1'b1);    step("drain");

    // Backpressure fills the skid buffer, then release.
    drive(1'b1, 32'h3000, 1'b0); step("bp0");
    drive(1'b1, 32'h3004, 1'b0); step("bp1");
    drive(1'b1, 32'h3008, 1'b0); step("bp_full");
    check("bp_ready_low", 64'(in_ready), 64'h0);
    drive(1'b0, 32'h0, 1'b1);    step("rel0");
    check("rel0_pc", 64'(out_pc), 64'h3004);
    drive(1'b0, 32'h0, 1'b1);    step("rel1");

    // Skid full plus flush: bubble takes the skid entry's PC.
    drive(1'b1, 32'h3000, 1'b0); step("fl0");
    drive(1'b1, 32'h3004, 1'b0); step("fl1");
    drive(1'b1, 32'h3010, 1'b0); flush = 1'b1; step("flush");
    check("flush_pc", 64'(out_pc), 64'h3004);
    flush = 1'b0;
    drive(1'b0, 32'h0, 1'b0); step("post_flush");

    // req beats flush: bubble at the handler PC.
    drive(1'b1, 32'h3010, 1'b1); in_bd = 1'b1; flush = 1'b1; req = 1'b1; step("req");
    check("req_pc", 64'(out_pc), 64'h4180);
    flush = 1'b0; req = 1'b0;

    // Exception code and delay-slot flag pass through, then reset mid-stall.
    drive(1'b1, 32'h3020, 1'b0); in_excode = 5'd4; in_bd = 1'b1; step("exc");
    check("exc_code", 64'(out_excode), 64'd4);
    drive(1'b1, 32'h3024, 1'b0); step("stall");
    reset = 1'b1; step("reset_mid");
    reset = 1'b0;
    drive(1'b0, 32'h0, 1'b0); step("after_reset");

`ifdef PIPE_STAGE_PERF_EN
    reset = 1'b1; step("perf_reset");
    reset = 1'b0;
    drive(1'b1, 32'h3100, 1'b0); step("perf_load");
    drive(1'b0, 32'h0, 1'b0);    step("perf_st0");
    step("perf_st1");
    step("perf_st2");
    drive(1'b0, 32'h0, 1'b1); flush = 1'b1; step("perf_fl0");
    step("perf_fl1");
    flush = 1'b0;
    check("perf_stall_3",  64'(perf_stall_cnt),  64'd3);
    check("perf_bubble_2", 64'(perf_bubble_cnt), 64'd2);
`endif

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      reset     = ($urandom_range(0, 63) == 0);
      req       = ($urandom_range(0, 23) == 0);
      flush     = ($urandom_range(0, 15) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_instr  = $urandom;
      in_pc     = $urandom & 32'hFFFF_FFFC;
      in_excode = 5'($urandom_range(0, 31));
      in_bd     = 1'($urandom_range(0, 1));
      step("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
